// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: multicycle sequencer for the 32x32 signed combinational multiplier.
// It owns the HI/LO registers. It holds the operands stable for SETTLE_CYCLES clocks,
// corrects the signed product for MULTU, and then writes HI/LO.
// Optional macro MULT_ACC_EN enables MADD/MADDU, which accumulate the product into {HI,LO}.
module mult_hilo_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_p,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt;
   logic [31:0] r_mul_a, r_mul_b, r_hi, r_lo;
   logic        r_unsigned, r_busy, r_done;
   logic        w_is_mul, w_accept, w_mthi, w_mtlo;
   logic [31:0] w_corr_a, w_corr_b, w_corr;
   logic [63:0] w_prod, w_result;
`ifdef MULT_ACC_EN
   logic        r_acc;
`endif

   // Classify the requested op; MADD/MADDU count as multiplies only when accumulation is built in
   always_comb begin
      w_is_mul = 1'b0;
      case (op)
         3'b000, 3'b001: w_is_mul = 1'b1;
`ifdef MULT_ACC_EN
         3'b100, 3'b101: w_is_mul = 1'b1;
`endif
         default:        w_is_mul = 1'b0;
      endcase
   end

   assign w_accept = (r_state == IDLE) && start && w_is_mul;
   assign w_mthi   = (r_state == IDLE) && start && (op == 3'b010);
   assign w_mtlo   = (r_state == IDLE) && start && (op == 3'b011);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic: RUN exits after the settle counter reaches zero
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = RUN;
         RUN:     if (r_cnt == '0) w_state_nxt = WRITE;
         WRITE:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Product formation. The unsigned correction only affects the upper word, so only
   // the low 32 bits of the correction sum are kept before they are shifted into HI.
   always_comb begin
      w_corr_a = r_mul_a[31] ? r_mul_b : '0;
      w_corr_b = r_mul_b[31] ? r_mul_a : '0;
      w_corr   = w_corr_a + w_corr_b;
      w_prod   = r_unsigned ? (mul_p + {w_corr, 32'h0000_0000}) : mul_p;
`ifdef MULT_ACC_EN
      w_result = r_acc ? ({r_hi, r_lo} + w_prod) : w_prod;
`else
      w_result = w_prod;
`endif
   end

   // Datapath: operand capture, settle counter, HI/LO writes, busy/done flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_mul_a    <= '0;
         r_mul_b    <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_unsigned <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef MULT_ACC_EN
         r_acc      <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_mul_a    <= rs_val;
                  r_mul_b    <= rt_val;
                  r_unsigned <= op[0];
`ifdef MULT_ACC_EN
                  r_acc      <= op[2];
`endif
                  r_cnt      <= CNT_INIT;
                  r_busy     <= 1'b1;
               end else if (w_mthi) begin
                  r_hi <= rs_val;
               end else if (w_mtlo) begin
                  r_lo <= rs_val;
               end
            end
            RUN: begin
               if (r_cnt != '0) r_cnt <= r_cnt - 4'd1;
            end
            WRITE: begin
               {r_hi, r_lo} <= w_result;
               r_done       <= 1'b1;
               r_busy       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign mul_a = r_mul_a;
   assign mul_b = r_mul_b;
   assign busy  = r_busy;
   assign done  = r_done;
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Scoreboard bench for mult_hilo_ctrl. The driver predicts each op's architectural effect
// and its due cycle. A negedge monitor compares busy/done/HI/LO/operands against those predictions.
module tb_mult_hilo_ctrl;
   localparam int unsigned S = 4;
`ifdef MULT_ACC_EN
   localparam bit ACC = 1'b1;
`else
   localparam bit ACC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] rs_val = '0, rt_val = '0;
   logic [31:0] mul_a, mul_b, hi, lo;
   logic [63:0] mul_p;
   logic        busy, done;

   mult_hilo_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   // Combinational signed multiplier: a product of sign-extended operands, taken mod 2^64
   assign mul_p = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        is_mul;
      int          acc_cyc;
      int          due_cyc;
      logic [31:0] a, b, hi, lo;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] cur_hi = '0, cur_lo = '0;     // architectural HI/LO as seen so far
   logic [31:0] pred_hi = '0, pred_lo = '0;   // HI/LO after all issued ops

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops an expectation on its due cycle and checks the outputs on every cycle
   always @(negedge clk) begin
      logic exp_busy, exp_done;
      if (rst_n) begin
         exp_busy = 1'b0;
         exp_done = 1'b0;
         if (q.size() > 0 && q[0].is_mul && q[0].acc_cyc <= cyc && cyc <= q[0].due_cyc) begin
            exp_busy = (cyc < q[0].due_cyc);
            chk("mul_a_hold", {32'h0, mul_a}, {32'h0, q[0].a});
            chk("mul_b_hold", {32'h0, mul_b}, {32'h0, q[0].b});
         end
         if (q.size() > 0 && q[0].due_cyc == cyc) begin
            exp_done = q[0].is_mul;
            cur_hi   = q[0].hi;
            cur_lo   = q[0].lo;
            void'(q.pop_front());
         end else if (q.size() > 0 && q[0].due_cyc < cyc) begin
            chk("overdue_result", 64'(cyc), 64'(q[0].due_cyc));
            void'(q.pop_front());
         end
         chk("busy", {63'h0, busy}, {63'h0, exp_busy});
         chk("done", {63'h0, done}, {63'h0, exp_done});
         chk("hi", {32'h0, hi}, {32'h0, cur_hi});
         chk("lo", {32'h0, lo}, {32'h0, cur_lo});
      end
   end

   // Issue one request at the current negedge (after waiting out busy) and predict its effect
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int unsigned w = 0;
      exp_t        e;
      logic [63:0] p;
      logic        valid;
      while (busy && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (busy) chk("busy_timeout", 64'(busy), 64'd0);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      e.a = a; e.b = b; e.acc_cyc = cyc + 1;
      valid = 1'b1;
      case (o)
         3'b000, 3'b100: p = longint'($signed(a)) * longint'($signed(b));
         3'b001, 3'b101: p = {32'h0, a} * {32'h0, b};
         default:        p = '0;
      endcase
      if (o == 3'b100 || o == 3'b101) begin
         valid = ACC;
         p = {pred_hi, pred_lo} + p;
      end
      if (o == 3'b110 || o == 3'b111) valid = 1'b0;
      if (valid) begin
         if (o == 3'b010 || o == 3'b011) begin
            e.is_mul  = 1'b0;
            e.due_cyc = e.acc_cyc;
            if (o == 3'b010) pred_hi = a;
            else             pred_lo = a;
         end else begin
            e.is_mul  = 1'b1;
            e.due_cyc = e.acc_cyc + int'(S) + 1;
            {pred_hi, pred_lo} = p;
         end
         e.hi = pred_hi;
         e.lo = pred_lo;
         q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // Assert start while the controller is busy; the request must be ignored
   task automatic poke(input logic [2:0] o, input logic [31:0] a);
      if (busy) begin
         start = 1'b1; op = o; rs_val = a; rt_val = a;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0001;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int unsigned w;
      // Reset state
      #1;
      chk("rst_busy", {63'h0, busy}, 64'd0);
      chk("rst_done", {63'h0, done}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors
      issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0002);
      issue(3'b001, 32'hFFFF_FFFF, 32'h0000_0002);
      issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(3'b000, 32'h8000_0000, 32'h8000_0000);
      issue(3'b010, 32'h1234_5678, 32'h0);
      issue(3'b011, 32'h9ABC_DEF0, 32'h0);
      issue(3'b000, 32'h0000_0003, 32'hFFFF_FFFB);
      poke(3'b010, 32'hDEAD_BEEF);
      poke(3'b000, 32'h0000_0007);
      issue(3'b010, 32'h0000_0000, 32'h0);
      issue(3'b011, 32'hFFFF_FFFF, 32'h0);
      issue(3'b101, 32'h0000_0001, 32'h0000_0001);
      issue(3'b110, 32'h5555_5555, 32'h2);
      issue(3'b111, 32'hAAAA_AAAA, 32'h3);

      // Reset in the middle of RUN discards the operation
      issue(3'b001, 32'hFFFF_FFFF, 32'h1234_5678);
      @(negedge clk);
      #2 rst_n = 1'b0;
      q.delete();
      cur_hi = '0; cur_lo = '0; pred_hi = '0; pred_lo = '0;
      #1;
      chk("midrun_rst_busy", {63'h0, busy}, 64'd0);
      chk("midrun_rst_done", {63'h0, done}, 64'd0);
      chk("midrun_rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (S + 4) @(negedge clk);

      // Randomized traffic, with ignored requests mixed in while busy
      for (int i = 0; i < 80; i++) begin
         issue(3'($urandom_range(0, 7)), pick(), pick());
         if ($urandom_range(0, 3) == 0) poke(3'($urandom_range(0, 7)), pick());
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      w = 0;
      while (q.size() > 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 64'd0);
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
